// File: rtl/systolic_seq_ctrl.sv
// Sequencer for an output-stationary NxN systolic array: latches A/B, clears the PEs,
// streams skewed operand wavefronts into the west/north edges, then waits for the display block.
`timescale 1ns/1ps

module systolic_seq_ctrl #(
    parameter int N = 2,
    parameter int W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [N*N*W-1:0]   mat_a,
    input  logic [N*N*W-1:0]   mat_b,
    input  logic [1:0]         disp_ack,
    output logic [N*W-1:0]     a_feed,
    output logic [N*W-1:0]     b_feed,
    output logic [N-1:0]       feed_valid,
    output logic               pe_clear,
    output logic [1:0]         state,
    output logic               busy,
    output logic               done,
    output logic [7:0]         run_cnt
);

    localparam int LAST_STEP = 3 * N - 3;
    localparam int SW        = $clog2(3 * N - 2);

    // Encoding is shared with the display block, which decodes it directly.
    typedef enum logic [1:0] {
        S_IDLE    = 2'b00,
        S_LOAD    = 2'b01,
        S_COMPUTE = 2'b10,
        S_DISPLAY = 2'b11
    } state_t;

    state_t             state_q, state_d;
    logic [SW-1:0]      step_q, step_d;
    logic [N*N*W-1:0]   a_lat_q, a_lat_d;
    logic [N*N*W-1:0]   b_lat_q, b_lat_d;
    logic               done_q, done_d;
    logic [7:0]         run_cnt_q, run_cnt_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            step_q    <= '0;
            a_lat_q   <= '0;
            b_lat_q   <= '0;
            done_q    <= 1'b0;
            run_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            step_q    <= step_d;
            a_lat_q   <= a_lat_d;
            b_lat_q   <= b_lat_d;
            done_q    <= done_d;
            run_cnt_q <= run_cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        step_d    = step_q;
        a_lat_d   = a_lat_q;
        b_lat_d   = b_lat_q;
        done_d    = 1'b0;
        run_cnt_d = run_cnt_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    a_lat_d = mat_a;
                    b_lat_d = mat_b;
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                step_d  = '0;
                state_d = S_COMPUTE;
            end
            S_COMPUTE: begin
                if (step_q == SW'(LAST_STEP)) begin
                    state_d = S_DISPLAY;
                end else begin
                    step_d = step_q + SW'(1);
                end
            end
            S_DISPLAY: begin
                // Only the "results shown" code releases the hold; anything else is ignored.
                if (disp_ack == 2'b10) begin
                    state_d   = S_IDLE;
                    done_d    = 1'b1;
                    run_cnt_d = run_cnt_q + 8'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Lane i carries A[i][t-i] and B[t-i][i] while i <= t <= i+N-1; the skew gives the wavefront.
    always_comb begin
        a_feed     = '0;
        b_feed     = '0;
        feed_valid = '0;
        if (state_q == S_COMPUTE) begin
            for (int i = 0; i < N; i++) begin
                if ((int'(step_q) >= i) && (int'(step_q) <= i + N - 1)) begin
                    feed_valid[i]     = 1'b1;
                    a_feed[i*W +: W]  = a_lat_q[(i*N + int'(step_q) - i)*W +: W];
                    b_feed[i*W +: W]  = b_lat_q[((int'(step_q) - i)*N + i)*W +: W];
                end
            end
        end
    end

    assign pe_clear = (state_q == S_LOAD);
    assign state    = state_q;
    assign busy     = (state_q != S_IDLE);
    assign done     = done_q;
    assign run_cnt  = run_cnt_q;

endmodule
